// File: rtl/id_pkg.sv
// Shared decode constants, control bundle layout and the hazard FSM state type
// for the MIPS ID stage.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_REST  = 2'd0;
    localparam logic [1:0] ALUOP_RTYPE = 2'd1;
    localparam logic [1:0] ALUOP_ADDI  = 2'd2;
    localparam logic [1:0] ALUOP_MEM   = 2'd3;

    localparam logic [1:0] DMEM_NOAC = 2'd0;
    localparam logic [1:0] DMEM_BYTE = 2'd1;
    localparam logic [1:0] DMEM_HALF = 2'd2;
    localparam logic [1:0] DMEM_WORD = 2'd3;

    localparam int CTRL_W        = 10;
    localparam int CTRL_REGWRITE = 9;
    localparam int CTRL_MEMTOREG = 8;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_ALUOP    = 2;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_REGDST   = 0;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic [1:0] memread;
        logic [1:0] memwrite;
        logic [1:0] aluop;
        logic       alusrc;
        logic       regdst;
    } ctrl_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } id_state_e;

    // Load/store opcodes encode the access size in their two low bits.
    function automatic logic [1:0] mem_size(input logic [5:0] op);
        case (op[1:0])
            2'b00:   return DMEM_BYTE;
            2'b01:   return DMEM_HALF;
            default: return DMEM_WORD;
        endcase
    endfunction

endpackage

// File: rtl/id_regfile.sv
// NREG x XLEN register file, two combinational read ports with same-cycle
// write-back bypass, one write port; r0 and out-of-range addresses read as zero.
module id_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [4:0]      ra_addr_i,
    input  logic [4:0]      rb_addr_i,
    output logic [XLEN-1:0] ra_data_o,
    output logic [XLEN-1:0] rb_data_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [XLEN-1:0] regs_q [NREG];

    function automatic logic in_range(input logic [4:0] a);
        return ({1'b0, a} < 6'(NREG));
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i && waddr_i != 5'd0 && in_range(waddr_i)) begin
            regs_q[waddr_i[IW-1:0]] <= wdata_i;
        end
    end

    // Zero for r0 / unmapped addresses takes priority over the bypass.
    always_comb begin
        ra_data_o = regs_q[ra_addr_i[IW-1:0]];
        if (we_i && waddr_i == ra_addr_i) ra_data_o = wdata_i;
        if (ra_addr_i == 5'd0 || !in_range(ra_addr_i)) ra_data_o = '0;

        rb_data_o = regs_q[rb_addr_i[IW-1:0]];
        if (we_i && waddr_i == rb_addr_i) rb_data_o = wdata_i;
        if (rb_addr_i == 5'd0 || !in_range(rb_addr_i)) rb_data_o = '0;
    end

endmodule

// File: rtl/id_stage_hazard.sv
// MIPS decode stage: decode, register read, load-use / branch-operand stall
// control, branch/jump redirect and the registered ID/EX handoff.
module id_stage_hazard
    import id_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int LU_STALLS = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     inst_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic            ex_ready_i,
    output logic            stall_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            illegal_o,
    output logic            ex_valid_o,
    output logic [9:0]      ex_ctrl_o,
    output logic [4:0]      ex_rs_o,
    output logic [4:0]      ex_rt_o,
    output logic [4:0]      ex_rd_o,
    output logic [5:0]      ex_funct_o,
    output logic [XLEN-1:0] ex_rsdata_o,
    output logic [XLEN-1:0] ex_rtdata_o,
    output logic [XLEN-1:0] ex_imm_o
);
    localparam logic [2:0] LU_N = 3'(LU_STALLS);

    logic [5:0]      opcode;
    logic [4:0]      rs, rt, rd;
    logic [XLEN-1:0] rs_data, rt_data, imm_sext;

    assign opcode   = inst_i[31:26];
    assign rs       = inst_i[25:21];
    assign rt       = inst_i[20:16];
    assign rd       = inst_i[15:11];
    assign imm_sext = {{(XLEN-16){inst_i[15]}}, inst_i[15:0]};

    id_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ra_addr_i (rs),
        .rb_addr_i (rt),
        .ra_data_o (rs_data),
        .rb_data_o (rt_data),
        .we_i      (wb_we_i),
        .waddr_i   (wb_addr_i),
        .wdata_i   (wb_data_i)
    );

    ctrl_t dec_ctrl;
    logic  is_beq, is_j, is_legal;

    always_comb begin
        dec_ctrl = '0;
        is_beq   = 1'b0;
        is_j     = 1'b0;
        is_legal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                dec_ctrl.regwrite = 1'b1;
                dec_ctrl.aluop    = ALUOP_RTYPE;
                dec_ctrl.regdst   = 1'b1;
            end
            OP_ADDI: begin
                dec_ctrl.regwrite = 1'b1;
                dec_ctrl.aluop    = ALUOP_ADDI;
                dec_ctrl.alusrc   = 1'b1;
            end
            OP_LB, OP_LH, OP_LW: begin
                dec_ctrl.regwrite = 1'b1;
                dec_ctrl.memtoreg = 1'b1;
                dec_ctrl.memread  = mem_size(opcode);
                dec_ctrl.aluop    = ALUOP_MEM;
                dec_ctrl.alusrc   = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                dec_ctrl.memwrite = mem_size(opcode);
                dec_ctrl.aluop    = ALUOP_MEM;
                dec_ctrl.alusrc   = 1'b1;
            end
            OP_BEQ:  is_beq   = 1'b1;
            OP_J:    is_j     = 1'b1;
            default: is_legal = 1'b0;
        endcase
    end

    logic            ex_valid_q;
    ctrl_t           ex_ctrl_q;
    logic [4:0]      ex_rs_q, ex_rt_q, ex_rd_q;
    logic [5:0]      ex_funct_q;
    logic [XLEN-1:0] ex_rsdata_q, ex_rtdata_q, ex_imm_q;

    function automatic logic src_hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    logic       advance, ex_is_load, lu_hz, br_hz, hazard;
    logic [4:0] ex_dest;
    logic [2:0] n_bub;

    assign advance    = ~ex_valid_q | ex_ready_i;
    assign ex_dest    = ex_ctrl_q.regdst ? ex_rd_q : ex_rt_q;
    assign ex_is_load = ex_valid_q && (ex_ctrl_q.memread != DMEM_NOAC);
    assign lu_hz      = valid_i && ex_is_load && (src_hit(rs, ex_rt_q) || src_hit(rt, ex_rt_q));
    assign br_hz      = valid_i && is_beq && ex_valid_q && ex_ctrl_q.regwrite
                        && (src_hit(rs, ex_dest) || src_hit(rt, ex_dest));
    assign hazard     = lu_hz || br_hz;
    // A beq waiting on a load must also cover the load's own use latency.
    assign n_bub      = br_hz ? (ex_is_load ? LU_N + 3'd1 : 3'd1) : LU_N;

    id_state_e  state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       bubble;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bubble  = 1'b0;
        if (flush_i) begin
            state_d = RUN;
            cnt_d   = 2'd0;
        end else if (advance) begin
            case (state_q)
                RUN: begin
                    if (hazard) begin
                        bubble = 1'b1;
                        cnt_d  = 2'(n_bub - 3'd1);
                        if (n_bub > 3'd1) state_d = STALL;
                    end
                end
                STALL: begin
                    bubble = 1'b1;
                    cnt_d  = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = RUN;
                        cnt_d   = 2'd0;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_q  <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_rd_q     <= '0;
            ex_funct_q  <= '0;
            ex_rsdata_q <= '0;
            ex_rtdata_q <= '0;
            ex_imm_q    <= '0;
        end else if (flush_i) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
        end else if (advance) begin
            ex_valid_q  <= valid_i && !bubble;
            ex_ctrl_q   <= (valid_i && !bubble) ? dec_ctrl : '0;
            ex_rs_q     <= rs;
            ex_rt_q     <= rt;
            ex_rd_q     <= rd;
            ex_funct_q  <= inst_i[5:0];
            ex_rsdata_q <= rs_data;
            ex_rtdata_q <= rt_data;
            ex_imm_q    <= imm_sext;
        end
    end

    assign stall_o       = ~rst_i & valid_i & ~flush_i & (hazard | (state_q == STALL) | ~advance);
    assign redirect_o    = ~rst_i & valid_i & ~stall_o & ~flush_i
                           & (is_j | (is_beq & (rs_data == rt_data)));
    assign redirect_pc_o = is_j ? {pc_i[XLEN-1:28], inst_i[25:0], 2'b00}
                                : pc_i + (imm_sext << 2);
    assign illegal_o     = ~rst_i & valid_i & ~is_legal;

    assign ex_valid_o  = ex_valid_q;
    assign ex_ctrl_o   = ex_ctrl_q;
    assign ex_rs_o     = ex_rs_q;
    assign ex_rt_o     = ex_rt_q;
    assign ex_rd_o     = ex_rd_q;
    assign ex_funct_o  = ex_funct_q;
    assign ex_rsdata_o = ex_rsdata_q;
    assign ex_rtdata_o = ex_rtdata_q;
    assign ex_imm_o    = ex_imm_q;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Bench for id_stage_hazard: directed scenarios plus random traffic, all checked
// every cycle against a bubble-debt reference model of the ID stage.
module tb_id_stage_hazard;
    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int LU   = 2;

    logic clk = 1'b0;
    logic rst, flush, valid, we, ready;
    logic [31:0] pc, inst, wd;
    logic [4:0]  wa;
    logic stall_o, redirect_o, illegal_o, ex_valid_o;
    logic [31:0] redirect_pc_o, ex_rsdata_o, ex_rtdata_o, ex_imm_o;
    logic [9:0]  ex_ctrl_o;
    logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
    logic [5:0]  ex_funct_o;

    always #5 clk = ~clk;

    id_stage_hazard #(.XLEN(XLEN), .NREG(NREG), .LU_STALLS(LU)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .pc_i(pc), .inst_i(inst),
        .wb_we_i(we), .wb_addr_i(wa), .wb_data_i(wd), .ex_ready_i(ready),
        .stall_o(stall_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .illegal_o(illegal_o), .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o),
        .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o), .ex_funct_o(ex_funct_o),
        .ex_rsdata_o(ex_rsdata_o), .ex_rtdata_o(ex_rtdata_o), .ex_imm_o(ex_imm_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state: architectural registers, expected ID/EX contents,
    // and the number of bubbles still owed to an earlier hazard.
    logic [31:0] m_rf [32];
    logic        m_v, m_known, m_last_stall;
    logic [9:0]  m_ctrl;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [5:0]  m_fn;
    logic [31:0] m_a, m_b, m_imm;
    int          m_owed;
    logic [31:0] prog_q[$];

    function automatic logic [9:0] exp_ctrl(input logic [5:0] op);
        case (op)
            6'h00: return 10'b1_0_00_00_01_0_1;
            6'h08: return 10'b1_0_00_00_10_1_0;
            6'h20: return 10'b1_1_01_00_11_1_0;
            6'h21: return 10'b1_1_10_00_11_1_0;
            6'h23: return 10'b1_1_11_00_11_1_0;
            6'h28: return 10'b0_0_00_01_11_1_0;
            6'h29: return 10'b0_0_00_10_11_1_0;
            6'h2B: return 10'b0_0_00_11_11_1_0;
            default: return 10'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h08, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B, 6'h04, 6'h02};
    endfunction

    function automatic logic [31:0] rdm(input logic [4:0] a);
        if (a == 5'd0 || int'(a) >= NREG) return 32'd0;
        if (we && wa == a) return wd;
        return m_rf[a];
    endfunction

    function automatic logic [31:0] r_ins(input int s, input int t, input int d, input int fn);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int s, input int t, input int imm);
        return {op, 5'(s), 5'(t), 16'(imm)};
    endfunction

    task automatic step();
        logic [5:0]  op;
        logic [4:0]  a, b, d, dst;
        logic [31:0] ad, bd, sx, tgt;
        logic        adv, lu, br, hz, es, er, ei;
        int          nb;
        #1;
        op = inst[31:26]; a = inst[25:21]; b = inst[20:16]; d = inst[15:11];
        ad = rdm(a); bd = rdm(b);
        sx = {{16{inst[15]}}, inst[15:0]};
        adv = !m_v || ready;
        dst = m_ctrl[0] ? m_rd : m_rt;
        lu = valid && m_v && (m_ctrl[7:6] != 2'd0)
             && ((a != 0 && a == m_rt) || (b != 0 && b == m_rt));
        br = valid && op == 6'h04 && m_v && m_ctrl[9]
             && ((a != 0 && a == dst) || (b != 0 && b == dst));
        hz = lu || br;
        nb = br ? ((m_ctrl[7:6] != 2'd0) ? LU + 1 : 1) : LU;
        es = !rst && valid && !flush && (hz || m_owed > 0 || !adv);
        er = !rst && valid && !es && !flush && (op == 6'h02 || (op == 6'h04 && ad == bd));
        ei = !rst && valid && !is_legal(op);
        tgt = (op == 6'h02) ? {pc[31:28], inst[25:0], 2'b00} : pc + (sx << 2);
        chk("stall", 32'(stall_o), 32'(es));
        chk("redirect", 32'(redirect_o), 32'(er));
        chk("illegal", 32'(illegal_o), 32'(ei));
        if (er) chk("redirect_pc", redirect_pc_o, tgt);
        m_last_stall = es;

        if (rst) begin
            m_v = 0; m_ctrl = 0; m_owed = 0; m_known = 1;
            m_rs = 0; m_rt = 0; m_rd = 0; m_fn = 0; m_a = 0; m_b = 0; m_imm = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
        end else begin
            if (flush) begin
                m_v = 0; m_ctrl = 0; m_owed = 0; m_known = 0;
            end else if (adv) begin
                if (m_owed > 0 || hz || !valid) begin
                    m_v = 0; m_ctrl = 0; m_known = 0;
                    if (m_owed > 0) m_owed--;
                    else if (hz) m_owed = nb - 1;
                end else begin
                    m_v = 1; m_ctrl = exp_ctrl(op); m_known = 1;
                    m_rs = a; m_rt = b; m_rd = d; m_fn = inst[5:0];
                    m_a = ad; m_b = bd; m_imm = sx;
                end
            end
            if (we && wa != 0 && int'(wa) < NREG) m_rf[wa] = wd;
        end

        @(negedge clk);
        chk("ex_valid", 32'(ex_valid_o), 32'(m_v));
        chk("ex_ctrl", 32'(ex_ctrl_o), 32'(m_ctrl));
        if (m_known) begin
            chk("ex_rs", 32'(ex_rs_o), 32'(m_rs));
            chk("ex_rt", 32'(ex_rt_o), 32'(m_rt));
            chk("ex_rd", 32'(ex_rd_o), 32'(m_rd));
            chk("ex_funct", 32'(ex_funct_o), 32'(m_fn));
            chk("ex_rsdata", ex_rsdata_o, m_a);
            chk("ex_rtdata", ex_rtdata_o, m_b);
            chk("ex_imm", ex_imm_o, m_imm);
        end
    endtask

    task automatic idle();
        rst = 0; flush = 0; valid = 0; we = 0; ready = 1;
        wa = 0; wd = 0; inst = 0;
    endtask

    task automatic wb(input int r, input logic [31:0] v);
        idle(); we = 1; wa = 5'(r); wd = v;
        step();
    endtask

    // Feeds queued instructions, holding each while the model expects a stall.
    task automatic run_prog();
        int guard = 0;
        while (prog_q.size() > 0 && guard < 40) begin
            idle(); valid = 1; inst = prog_q[0]; pc = pc + 4;
            step();
            if (!m_last_stall) void'(prog_q.pop_front());
            guard++;
        end
        chk("prog_drained", 32'(prog_q.size()), 32'd0);
        prog_q.delete();
    endtask

    function automatic logic [4:0] rreg();
        return ($urandom_range(0, 9) == 0) ? 5'($urandom_range(14, 31)) : 5'($urandom_range(0, 5));
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] op;
        case ($urandom_range(0, 11))
            0: op = 6'h00;  1: op = 6'h08;  2: op = 6'h20;  3: op = 6'h21;
            4: op = 6'h23;  5: op = 6'h28;  6: op = 6'h29;  7: op = 6'h2B;
            8: op = 6'h04;  9: op = 6'h02;  10: op = 6'h3F; default: op = 6'h11;
        endcase
        return {op, rreg(), rreg(), rreg(), 11'($urandom)};
    endfunction

    initial begin
        idle(); pc = 32'h0040_0000;
        m_v = 0; m_ctrl = 0; m_owed = 0; m_known = 0; m_last_stall = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        @(negedge clk);
        rst = 1; step(); step();
        idle();

        wb(1, 32'd7); wb(2, 32'd7); wb(4, 32'd3);

        // Bypass: r5 written in the same cycle addi r6,r5,1 reads it.
        idle(); valid = 1; we = 1; wa = 5'd5; wd = 32'hDEAD;
        inst = i_ins(6'h08, 5, 6, 1); step();
        chk("bypass_rsdata", ex_rsdata_o, 32'hDEAD);

        // Load-use with two bubbles.
        prog_q.push_back(i_ins(6'h23, 1, 2, 0));
        prog_q.push_back(r_ins(2, 4, 3, 32));
        run_prog();

        // add writing r1, then beq r1,r2 (equal) and a jump.
        prog_q.push_back(r_ins(2, 0, 1, 32));
        prog_q.push_back(i_ins(6'h04, 1, 2, 3));
        prog_q.push_back({6'h02, 26'h123456});
        run_prog();

        // Backpressure: valid ID/EX held while EX refuses it.
        idle(); valid = 1; inst = i_ins(6'h08, 1, 7, 5); step();
        for (int i = 0; i < 3; i++) begin
            idle(); valid = 1; ready = 0; inst = i_ins(6'h2B, 2, 4, 8); step();
        end
        idle(); valid = 1; inst = i_ins(6'h2B, 2, 4, 8); step();

        // Flush while one bubble is still owed, then illegal opcode.
        idle(); valid = 1; inst = i_ins(6'h23, 1, 2, 0); step();
        idle(); valid = 1; inst = r_ins(2, 4, 3, 32); step();
        chk("owed_before_flush", 32'(m_owed), 32'd1);
        idle(); valid = 1; flush = 1; inst = r_ins(2, 4, 3, 32); step();
        idle(); valid = 1; inst = r_ins(2, 4, 3, 32); step();
        idle(); valid = 1; inst = {6'h3F, 26'h0}; step();

        for (int n = 0; n < 600; n++) begin
            idle();
            valid = ($urandom_range(0, 99) < 85);
            flush = ($urandom_range(0, 19) == 0);
            ready = ($urandom_range(0, 99) < 70);
            we    = $urandom_range(0, 1);
            wa    = 5'($urandom_range(0, 19));
            wd    = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
            pc    = $urandom;
            inst  = rand_inst();
            step();
        end

        // Reset in the middle of a load-use stall, then read r5.
        idle(); valid = 1; inst = i_ins(6'h23, 1, 2, 0); step();
        idle(); valid = 1; inst = r_ins(2, 4, 3, 32); step();
        idle(); rst = 1; valid = 1; inst = r_ins(2, 4, 3, 32); step();
        idle(); valid = 1; inst = r_ins(2, 4, 3, 32); step();
        idle(); valid = 1; inst = i_ins(6'h08, 5, 6, 1); step();
        chk("r5_after_reset", ex_rsdata_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
